// File: rtl/dlx_pkg.sv
// Shared DLX constants and the memory-stage FSM state encoding.
// No logic and no latency; backpressure does not apply.
// Imported by mem_wait_fsm and mem_stage.
package dlx_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Access-latency sequencer for the memory stage: stalls while an access is pending.
// Latency MEM_LAT cycles per access; complete pulses in the final cycle.
// Holds the stall for MEM_LAT-1 cycles; start must stay stable while stalled.
module mem_wait_fsm
    import dlx_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic stall_mem,
    output logic complete
);

    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_mem = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    // A single-cycle RAM never needs the WAIT state.
                    if (MEM_LAT == 1) begin
                        complete = 1'b1;
                    end else begin
                        stall_mem = 1'b1;
                        cnt_nxt   = CNT_INIT;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    stall_mem = 1'b1;
                    cnt_nxt   = cnt - CNT_W'(1);
                end else begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// DLX memory stage: word load/store on internal RAM, registers the writeback bundle.
// Latency 1 cycle for non-memory ops, MEM_LAT cycles for loads/stores.
// Raises stall_mem for MEM_LAT-1 cycles per access; optional MEM_MISALIGN_TRAP_EN.
module mem_stage
    import dlx_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     Result,
    input  logic [DATA_W-1:0]     mem_data_ex,
    input  logic                  MemWrite_mem,
    input  logic                  MemtoReg_mem,
    input  logic                  RegWrite_mem,
    input  logic [REG_ADDR_W-1:0] towrite_ex,
    output logic [DATA_W-1:0]     result_mem,
    output logic [REG_ADDR_W-1:0] towrite_mem,
    output logic                  RegWrite_wb,
    output logic                  stall_mem,
    output logic                  misalign
);

    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] ram [DEPTH];
    logic              mem_op;
    logic              is_load;
    logic              complete;
    logic              bad_addr;
    logic              store_commit;
    logic [DATA_W-1:0] wb_val;
    logic              unused_addr_bits;

    assign idx     = Result[ADDR_W+1:2];
    assign mem_op  = MemWrite_mem | MemtoReg_mem;
    // Store wins when both request bits are set; writeback is then Result.
    assign is_load = MemtoReg_mem & ~MemWrite_mem;
    assign unused_addr_bits = ^{Result[DATA_W-1:ADDR_W+2], Result[1:0]};

`ifdef MEM_MISALIGN_TRAP_EN
    assign bad_addr = mem_op & (Result[1:0] != 2'b00);
`else
    assign bad_addr = 1'b0;
`endif

    mem_wait_fsm #(
        .MEM_LAT (MEM_LAT)
    ) u_wait_fsm (
        .clk       (clk),
        .reset     (reset),
        .start     (mem_op),
        .stall_mem (stall_mem),
        .complete  (complete)
    );

    // Reset in the completing cycle aborts the store as well.
    assign store_commit = complete & MemWrite_mem & ~bad_addr & ~reset;

    always_ff @(posedge clk) begin
        if (store_commit) begin
            ram[idx] <= mem_data_ex;
        end
    end

    always_comb begin
        wb_val = Result;
        if (is_load) begin
            wb_val = bad_addr ? '0 : ram[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_mem  <= '0;
            towrite_mem <= '0;
            RegWrite_wb <= 1'b0;
        end else if (stall_mem) begin
            RegWrite_wb <= 1'b0;
        end else begin
            result_mem  <= wb_val;
            towrite_mem <= towrite_ex;
            RegWrite_wb <= RegWrite_mem & (towrite_ex != REG_ZERO) & ~bad_addr;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (!stall_mem) begin
            misalign <= bad_addr;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with MEM_LAT=3, DEPTH=256.
// Define MEM_MISALIGN_TRAP_EN to exercise the misaligned-access trap.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Result;
    logic [31:0] mem_data_ex;
    logic        MemWrite_mem;
    logic        MemtoReg_mem;
    logic        RegWrite_mem;
    logic [4:0]  towrite_ex;
    logic [31:0] result_mem;
    logic [4:0]  towrite_mem;
    logic        RegWrite_wb;
    logic        stall_mem;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    mem_stage #(
        .DEPTH   (256),
        .ADDR_W  (8),
        .MEM_LAT (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Result       (Result),
        .mem_data_ex  (mem_data_ex),
        .MemWrite_mem (MemWrite_mem),
        .MemtoReg_mem (MemtoReg_mem),
        .RegWrite_mem (RegWrite_mem),
        .towrite_ex   (towrite_ex),
        .result_mem   (result_mem),
        .towrite_mem  (towrite_mem),
        .RegWrite_wb  (RegWrite_wb),
        .stall_mem    (stall_mem),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] res, input logic [31:0] dat,
                         input logic mw, input logic mr, input logic rw, input logic [4:0] rd);
        Result       = res;
        mem_data_ex  = dat;
        MemWrite_mem = mw;
        MemtoReg_mem = mr;
        RegWrite_mem = rw;
        towrite_ex   = rd;
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge.
    task automatic op(input logic [31:0] res, input logic [31:0] dat,
                      input logic mw, input logic mr, input logic rw, input logic [4:0] rd,
                      output int nst);
        bit done;
        drive(res, dat, mw, mr, rw, rd);
        nst  = 0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall_mem) begin
                done = 1'b1;
                break;
            end
            nst++;
            @(posedge clk);
            #1;
            chk("bubble_rw", {31'b0, RegWrite_wb}, 32'd0);
        end
        if (!done) chk("stall_timeout", 32'(nst), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result_mem, 32'd0);
        chk("rst_towrite", {27'b0, towrite_mem}, 32'd0);
        chk("rst_rw", {31'b0, RegWrite_wb}, 32'd0);
        chk("rst_stall", {31'b0, stall_mem}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        reset = 1'b0;

        op(32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, n);
        chk("add_stalls", 32'(n), 32'd0);
        chk("add_result", result_mem, 32'h0000_1234);
        chk("add_towrite", {27'b0, towrite_mem}, 32'd7);
        chk("add_rw", {31'b0, RegWrite_wb}, 32'd1);

        op(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 5'd0, n);
        chk("st_stalls", 32'(n), 32'd2);
        chk("st_rw", {31'b0, RegWrite_wb}, 32'd0);
        op(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, n);
        chk("ld_stalls", 32'(n), 32'd2);
        chk("ld_result", result_mem, 32'hDEAD_BEEF);
        chk("ld_towrite", {27'b0, towrite_mem}, 32'd5);
        chk("ld_rw", {31'b0, RegWrite_wb}, 32'd1);

        // 0x400 wraps to word 0; load is back-to-back with the store.
        op(32'h400, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 5'd3, n);
        op(32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, n);
        chk("wrap_result", result_mem, 32'hA5A5_A5A5);
        chk("wrap_towrite", {27'b0, towrite_mem}, 32'd9);

        op(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, n);
        chk("r0_rw", {31'b0, RegWrite_wb}, 32'd0);
        chk("r0_result", result_mem, 32'h55);

        op(32'h14, 32'h7, 1'b1, 1'b1, 1'b1, 5'd4, n);
        chk("both_result", result_mem, 32'h14);
        op(32'h14, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, n);
        chk("both_stored", result_mem, 32'h7);

        op(32'h20, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 5'd0, n);

        // Reset in the 2nd cycle of a store.
        drive(32'h20, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        chk("ab1_stall0", {31'b0, stall_mem}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("ab1_stall1", {31'b0, stall_mem}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("ab1_stall_drop", {31'b0, stall_mem}, 32'd0);
        chk("ab1_result_rst", result_mem, 32'd0);
        @(posedge clk);
        #1;
        op(32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2, n);
        chk("ab1_ld", result_mem, 32'h1111_1111);

        // Reset in the final (completing) cycle of a store.
        drive(32'h20, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("ab2_stall", {31'b0, stall_mem}, 32'd0);
        @(posedge clk);
        #1;
        op(32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2, n);
        chk("ab2_ld", result_mem, 32'h1111_1111);

`ifdef MEM_MISALIGN_TRAP_EN
        op(32'h13, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8, n);
        chk("mis_ld_stalls", 32'(n), 32'd2);
        chk("mis_ld_flag", {31'b0, misalign}, 32'd1);
        chk("mis_ld_rw", {31'b0, RegWrite_wb}, 32'd0);
        chk("mis_ld_result", result_mem, 32'd0);
        op(32'h11, 32'h9999_9999, 1'b1, 1'b0, 1'b0, 5'd0, n);
        chk("mis_st_flag", {31'b0, misalign}, 32'd1);
        op(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8, n);
        chk("mis_ram_kept", result_mem, 32'hDEAD_BEEF);
        chk("mis_flag_clr", {31'b0, misalign}, 32'd0);
`else
        op(32'h12, 32'h0000_0044, 1'b1, 1'b0, 1'b0, 5'd0, n);
        op(32'h13, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8, n);
        chk("lowbits_ld", result_mem, 32'h0000_0044);
        chk("lowbits_flag", {31'b0, misalign}, 32'd0);
        chk("lowbits_rw", {31'b0, RegWrite_wb}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
